// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory read port and decode output slot
interface fetch_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - next-PC select and fetch control feeding a one-entry decode slot
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] PC_STEP      = 16'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              pc,
    output logic [15:0]              pc_pre,
    output logic                     pc_ld,
    input  logic                     redirect,
    input  logic [15:0]              redirect_addr,
    input  logic                     halt,
    fetch_sequencer_if.master        bus
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_FULL   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_discard;

    logic        w_pc_ld;
    logic [15:0] w_pc_pre;
    logic        w_capture;
    state_t      w_resume;

    assign w_capture = (r_state == ST_FETCH) && bus.imem_ack && !r_discard && !redirect;
    assign w_resume  = halt ? ST_HALTED : ST_FETCH;

    // rst_n gates the load so the PC register sees no pulse while reset is held in BOOT
    always_comb begin
        w_pc_ld  = 1'b0;
        w_pc_pre = 16'h0000;
        if (rst_n) begin
            if (r_state == ST_BOOT) begin
                w_pc_ld  = 1'b1;
                w_pc_pre = RESET_VECTOR;
            end else if (redirect) begin
                w_pc_ld  = 1'b1;
                w_pc_pre = redirect_addr;
            end else if (w_capture) begin
                w_pc_ld  = 1'b1;
                w_pc_pre = pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= w_resume;
                end
                ST_FETCH: begin
                    if (redirect) begin
                        r_instr_valid <= 1'b0;
                        if (bus.imem_ack) begin
                            r_discard <= 1'b0;
                            r_state   <= w_resume;
                        end else begin
                            // the in-flight read must still complete before the new pc is fetched
                            r_discard <= 1'b1;
                        end
                    end else if (bus.imem_ack) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= w_resume;
                        end else begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (redirect || bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= w_resume;
                    end
                end
                ST_HALTED: begin
                    r_state <= w_resume;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign pc_pre          = w_pc_pre;
    assign pc_ld           = w_pc_ld;
    assign bus.imem_req    = (r_state == ST_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector bench for fetch_sequencer with a PC register model
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] pc_pre;
    logic        pc_ld;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_VECTOR (16'h0000),
        .PC_STEP      (16'd1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .pc_pre        (pc_pre),
        .pc_ld         (pc_ld),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    // PC register: powers up at a junk value so the BOOT load is observable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc <= 16'hDEAD;
        else if (pc_ld) pc <= pc_pre;
    end

    typedef struct {
        logic        halt;
        logic        redir;
        logic [15:0] raddr;
        logic        ready;
        logic        ack;
        logic [15:0] rdata;
        logic        ld;
        logic [15:0] pre;
        logic        req;
        logic [15:0] pcv;
        logic        valid;
        logic [15:0] ipc;
        logic [15:0] ins;
    } vec_t;

    vec_t vt[29];

    function automatic vec_t mk(input logic h, input logic r, input logic [15:0] ra,
                                input logic rdy, input logic ak, input logic [15:0] rd,
                                input logic ld, input logic [15:0] pre, input logic rq,
                                input logic [15:0] pcv, input logic v,
                                input logic [15:0] ipc, input logic [15:0] ins);
        vec_t t;
        t.halt = h;  t.redir = r;  t.raddr = ra; t.ready = rdy; t.ack = ak; t.rdata = rd;
        t.ld = ld;   t.pre = pre;  t.req = rq;   t.pcv = pcv;   t.valid = v;
        t.ipc = ipc; t.ins = ins;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic r, input logic [15:0] ra,
                         input logic rdy, input logic ak, input logic [15:0] rd);
        halt = h; redirect = r; redirect_addr = ra;
        bus.instr_ready = rdy; bus.imem_ack = ak; bus.imem_rdata = rd;
    endtask

    initial begin
        vt[0]  = mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'hDEAD,0,16'h0000,16'h0000);
        vt[1]  = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,1,16'h0000,0,16'h0000,16'h0000);
        vt[2]  = mk(0,0,16'h0000,1,1,16'hA000, 1,16'h0001,1,16'h0000,0,16'h0000,16'h0000);
        vt[3]  = mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0001,1,16'h0000,16'hA000);
        vt[4]  = mk(0,0,16'h0000,1,1,16'hA001, 1,16'h0002,1,16'h0001,0,16'h0000,16'hA000);
        vt[5]  = mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0002,1,16'h0001,16'hA001);
        vt[6]  = mk(0,0,16'h0000,0,1,16'hA002, 1,16'h0003,1,16'h0002,0,16'h0001,16'hA001);
        for (int i = 7; i <= 11; i++)
            vt[i] = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0003,1,16'h0002,16'hA002);
        vt[12] = mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0003,1,16'h0002,16'hA002);
        vt[13] = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,1,16'h0003,0,16'h0002,16'hA002);
        vt[14] = mk(0,1,16'h1234,0,0,16'h0000, 1,16'h1234,1,16'h0003,0,16'h0002,16'hA002);
        vt[15] = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,1,16'h1234,0,16'h0002,16'hA002);
        vt[16] = mk(0,0,16'h0000,0,1,16'hBEEF, 0,16'h0000,1,16'h1234,0,16'h0002,16'hA002);
        vt[17] = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,1,16'h1234,0,16'h0002,16'hA002);
        vt[18] = mk(0,1,16'h0100,0,1,16'hC234, 1,16'h0100,1,16'h1234,0,16'h0002,16'hA002);
        vt[19] = mk(0,0,16'h0000,1,1,16'hC100, 1,16'h0101,1,16'h0100,0,16'h0002,16'hA002);
        vt[20] = mk(0,1,16'hFFFF,1,0,16'h0000, 1,16'hFFFF,0,16'h0101,1,16'h0100,16'hC100);
        vt[21] = mk(0,0,16'h0000,0,1,16'hDFFF, 1,16'h0000,1,16'hFFFF,0,16'h0100,16'hC100);
        vt[22] = mk(1,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,1,16'hFFFF,16'hDFFF);
        vt[23] = mk(1,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0000,1,16'hFFFF,16'hDFFF);
        vt[24] = mk(1,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,0,16'hFFFF,16'hDFFF);
        vt[25] = mk(1,1,16'h0040,0,0,16'h0000, 1,16'h0040,0,16'h0000,0,16'hFFFF,16'hDFFF);
        vt[26] = mk(1,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0040,0,16'hFFFF,16'hDFFF);
        vt[27] = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0040,0,16'hFFFF,16'hDFFF);
        vt[28] = mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0000,1,16'h0040,0,16'hFFFF,16'hDFFF);

        rst_n = 1'b0;
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc_ld",  0, {15'd0, pc_ld}, 16'h0000);
        chk("rst_pc_pre", 0, pc_pre, 16'h0000);
        chk("rst_req",    0, {15'd0, bus.imem_req}, 16'h0000);
        chk("rst_valid",  0, {15'd0, bus.instr_valid}, 16'h0000);
        chk("rst_instr",  0, bus.instr, 16'h0000);
        chk("rst_ipc",    0, bus.instr_pc, 16'h0000);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drive(vt[i].halt, vt[i].redir, vt[i].raddr, vt[i].ready, vt[i].ack, vt[i].rdata);
            #1;
            chk("pc_ld", i, {15'd0, pc_ld}, {15'd0, vt[i].ld});
            if (vt[i].ld) chk("pc_pre", i, pc_pre, vt[i].pre);
            chk("imem_req", i, {15'd0, bus.imem_req}, {15'd0, vt[i].req});
            chk("pc", i, pc, vt[i].pcv);
            if (vt[i].req) chk("imem_addr", i, bus.imem_addr, vt[i].pcv);
            chk("instr_valid", i, {15'd0, bus.instr_valid}, {15'd0, vt[i].valid});
            chk("instr_pc", i, bus.instr_pc, vt[i].ipc);
            chk("instr", i, bus.instr, vt[i].ins);
        end

        // async reset while a read is pending
        @(negedge clk);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        #1;
        chk("wait_req", 0, {15'd0, bus.imem_req}, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("arst_req",   0, {15'd0, bus.imem_req}, 16'h0000);
        chk("arst_pc_ld", 0, {15'd0, pc_ld}, 16'h0000);
        chk("arst_instr", 0, bus.instr, 16'h0000);
        chk("arst_ipc",   0, bus.instr_pc, 16'h0000);

        // reboot with halt held and a redirect that BOOT must ignore
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 16'h5555, 0, 0, 16'h0000);
        #1;
        chk("boot_pc_ld",  1, {15'd0, pc_ld}, 16'h0001);
        chk("boot_pc_pre", 1, pc_pre, 16'h0000);
        chk("boot_req",    1, {15'd0, bus.imem_req}, 16'h0000);
        @(negedge clk);
        drive(1, 0, 16'h0000, 0, 0, 16'h0000);
        #1;
        chk("bhalt_pc",    2, pc, 16'h0000);
        chk("bhalt_req",   2, {15'd0, bus.imem_req}, 16'h0000);
        chk("bhalt_pc_ld", 2, {15'd0, pc_ld}, 16'h0000);
        halt = 1'b0;
        @(negedge clk);
        #1;
        chk("resume_req",  3, {15'd0, bus.imem_req}, 16'h0001);
        chk("resume_addr", 3, bus.imem_addr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream next-PC and fetch control stage for the 16-bit PC register. The PC register takes pc_pre, pc_ld and clk; this block drives pc_pre and pc_ld and reads the registered pc back.
- Issues instruction-memory reads at pc over a req/ack handshake and holds the fetched word in a one-entry output slot for decode (valid/ready).
- Applies sequential increment, branch/jump redirect, and halt.

Parameters:
- RESET_VECTOR, 16'h0000, first PC loaded after reset release.
- PC_STEP, 16'd1, sequential increment (word-addressed memory).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  16  current PC from the PC register output.
- pc_pre  out  16  next-PC value to the PC register D input.
- pc_ld  out  1  load enable to the PC register (CE).
- imem_req  out  1  memory read request.
- imem_addr  out  16  read address; equals pc whenever imem_req=1.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  16  instruction word.
- redirect  in  1  single-cycle branch/jump taken.
- redirect_addr  in  16  target address; valid with redirect.
- halt  in  1  level; stop issuing new fetches.
- instr  out  16  fetched instruction.
- instr_pc  out  16  address instr was fetched from.
- instr_valid  out  1  output slot occupied.
- instr_ready  in  1  decode accepts instr this cycle.

Behaviour:
- Reset (rst_n=0, async):
  - state=BOOT; instr, instr_pc, instr_valid, discard flag cleared to 0.
  - Outputs: pc_ld=0, pc_pre=0, imem_req=0.
  - Reset mid-fetch abandons the request; the memory must tolerate the req drop.
- pc_pre and pc_ld are combinational from state and inputs. pc_ld is high for exactly one cycle per PC change. The PC register updates at the same edge.
- States: BOOT, FETCH, FULL, HALTED.
- BOOT:
  - First cycle after reset release: pc_pre=RESET_VECTOR, pc_ld=1.
  - Next state is FETCH if halt=0, else HALTED.
  - redirect is ignored in BOOT.
- FETCH:
  - imem_req=1 and imem_addr=pc every cycle.
  - req stays high until ack and is never withdrawn (except on reset).
- FETCH on imem_ack with no redirect and discard=0:
  - instr<=imem_rdata, instr_pc<=pc, instr_valid<=1.
  - pc_pre=pc+PC_STEP, truncated to 16 bits (16'hFFFF wraps to 16'h0000); pc_ld=1.
  - Next state FULL.
- FETCH on imem_ack with discard=1:
  - Data is dropped, discard<=0, pc_ld=0.
  - Stay in FETCH if halt=0, else HALTED.
- FULL:
  - instr_valid=1, imem_req=0. Output regs hold stable until accepted.
  - On instr_ready: instr_valid<=0 at the edge; next state is FETCH if halt=0, else HALTED.
  - Throughput is at most one instruction per 2 cycles with single-cycle ack.
- HALTED:
  - imem_req=0, instr_valid=0, pc held.
  - When halt falls: go to FETCH (pc unchanged).
- redirect (any state except BOOT); redirect has priority over increment and halt.
  - pc_pre=redirect_addr, pc_ld=1. instr_valid<=0 (flush slot).
  - FETCH without ack in the same cycle: discard<=1 and stay in FETCH. The outstanding request completes and is dropped, then the new pc is fetched.
  - FETCH with ack in the same cycle: data dropped; pc loads redirect_addr (not pc+PC_STEP); next state FETCH (or HALTED if halt=1).
  - FULL: slot flushed even if instr_ready=1 the same cycle (instruction lost); next state FETCH/HALTED per halt.
  - HALTED: pc loads target; state stays HALTED while halt=1.
- A second redirect while discard=1 only reloads pc; discard stays 1.
- instr_valid never rises in the cycle a redirect is sampled.

Test Plan:
- Reset release, halt=0, ack 1 cycle after req: pc_ld pulse with pc_pre=16'h0000 → req at 0000, 0001, 0002; instr_pc matches each; instr_valid high one cycle each with instr_ready=1.
- Backpressure: instr_ready=0 for 5 cycles in FULL → instr/instr_pc stable, imem_req=0, no pc_ld; ready=1 → next fetch at pc+1.
- Redirect during pending req (ack delayed 3 cycles), redirect_addr=16'h1234 → pc loads 1234 immediately, old data discarded (instr_valid stays 0), next req addr=1234.
- Redirect in the same cycle as ack → pc=redirect_addr, not pc+1; no instr_valid pulse; also redirect in FULL with instr_ready=1 → slot flushed.
- Wrap: redirect to 16'hFFFF, fetch completes → pc_pre=16'h0000, instr_pc=16'hFFFF.
- halt=1 while in FULL → after accept, state HALTED, no req; redirect to 16'h0040 while halted → pc=0040, still no req; halt=0 → req at 0040. Async rst_n low mid-WAIT → req drops immediately, BOOT reloads RESET_VECTOR.
